writeback_stage: RTL
====================

// Module: writeback_stage
// PURPOSE
// - MEM/WB pipeline register plus writeback datapath; sits directly upstream of the register file and drives its write port.
// - Captures MEM-stage results and sign/zero-extends sub-word loads by byte lane.
// - Selects ALU result or load data and issues writeEn/writeAddr/writeData in the WB cycle.
// - Exposes the WB destination and value to the forwarding unit.
// PARAMETERS
// - REG_ADDR_W    5   register index width; fixed at 5 for MIPS
// - RETIRE_CNT_W  32  retired-instruction counter width; used only when WB_RETIRE_CNT_EN is defined
// PORTS
// - clk            in   1   clock; all state updates on posedge
// - rst_n          in   1   synchronous active-low reset, sampled on posedge clk
// - stall          in   1   hold the MEM/WB register contents
// - flush          in   1   load a bubble into MEM/WB
// - mem_valid      in   1   MEM stage holds a real instruction
// - mem_regWrite   in   1   instruction writes a register
// - mem_memToReg   in   1   1 = load data, 0 = ALU result
// - mem_loadType   in   3   000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU; 101-111 treated as LW
// - mem_destReg    in   5   destination register index
// - mem_aluResult  in   32  ALU result or effective address
// - mem_readData   in   32  raw word from data memory
// - writeEn        out  1   register-file write enable
// - writeAddr      out  5   register-file write index
// - writeData      out  32  register-file write data
// - wb_fwdValid    out  1   equals writeEn; forwarding qualifier
// - wb_misalign    out  1   misaligned halfword load held in WB
// - retireCount    out  RETIRE_CNT_W  retired instructions (WB_RETIRE_CNT_EN only)
// BEHAVIOUR
// - Reset (rst_n=0 at posedge): all MEM/WB fields cleared, valid=0.
// - Outputs after reset: writeEn=0, writeAddr=0, writeData=0, wb_misalign=0, retireCount=0.
// - Posedge update priority, highest first:
//   1. rst_n=0
//   2. flush=1: valid=0, other fields don't-care, outputs forced inactive
//   3. stall=1: hold all fields
//   4. else: capture all mem_* inputs
// - flush overrides stall in the same cycle.
// - Latency: one cycle from MEM inputs to register-file outputs.
// - Outputs are combinational from the MEM/WB register. The register file writes on negedge, so data is stable half a cycle before the write.
// - Load extraction (little-endian):
//   - off = aluResult[1:0]
//   - LB/LBU: byte = readData[8*off +: 8]
//   - LH/LHU: half = readData[16*aluResult[1] +: 16]
//   - LB/LH sign-extend; LBU/LHU zero-extend
// - wb_misalign = valid & memToReg & (LH|LHU) & aluResult[0].
//   - When set, writeEn is forced to 0.
//   - LB/LW never assert wb_misalign; LW ignores off.
// - writeData = memToReg ? extendedLoad : aluResult.
// - writeEn = valid & regWrite & (destReg != 0) & ~wb_misalign.
// - writeAddr = destReg when writeEn=1, else 0.
// - writeData = 0 when writeEn=0.
// - Stall with valid=1: writeEn stays asserted and rewrites the same value each cycle. This is idempotent and permitted.
// - A reset asserted mid-stall or mid-flush clears state on that posedge. No write is issued on the following negedge.
// CONFIGURATION
// - WB_RETIRE_CNT_EN defined:
//   - retireCount increments by 1 on each posedge where valid=1, stall=0, and rst_n=1.
//   - The increment happens regardless of regWrite or misalign.
//   - Wraps from all-ones to 0. Reset clears it.
// - WB_RETIRE_CNT_EN undefined:
//   - retireCount port is absent and no counter logic exists.
// TESTING
// - Word load: LW, aluResult=0x1000, readData=0xDEADBEEF, dest=8 -> next cycle writeEn=1, writeAddr=8, writeData=0xDEADBEEF.
// - Byte lanes: LB, off=3, readData=0x80FF7F01 -> writeData=0xFFFFFF80. Same with LBU -> writeData=0x00000080.
// - Halfwords: LH, aluResult=0x2, readData=0x8001_1234 -> writeData=0xFFFF8001. Same with aluResult=0x3 -> wb_misalign=1, writeEn=0.
// - Register $0 and stall/flush:
//   - dest=0, regWrite=1 -> writeEn=0.
//   - stall 3 cycles -> outputs held.
//   - stall=1 and flush=1 together -> writeEn=0 next cycle.
// - Reset: rst_n=0 mid-stream with a pending write -> next cycle writeEn=0, writeData=0, retireCount=0.
// - Counter (WB_RETIRE_CNT_EN): 5 valid unstalled, 2 stalled, 1 flushed instructions -> retireCount=5.
//   - With RETIRE_CNT_W=4 preloaded to 15 -> one retire wraps it to 0.

Source files
------------

// File: rtl/writeback_stage_if.sv
// writeback_stage_if: MEM-stage inputs and register-file write port of the writeback stage
// Optional: WB_RETIRE_CNT_EN adds retireCount and the RETIRE_CNT_W parameter.
// master (pipeline/bench) drives stall, flush and mem_*, and observes the WB outputs.
// slave (writeback_stage) observes stall, flush and mem_*, and drives writeEn, writeAddr,
//   writeData, wb_fwdValid, wb_misalign and retireCount.
interface writeback_stage_if #(
    parameter int REG_ADDR_W = 5
`ifdef WB_RETIRE_CNT_EN
    , parameter int RETIRE_CNT_W = 32
`endif
);
    logic stall, flush;
    logic mem_valid, mem_regWrite, mem_memToReg;
    logic [2:0] mem_loadType;
    logic [REG_ADDR_W-1:0] mem_destReg;
    logic [31:0] mem_aluResult, mem_readData;
    logic writeEn, wb_fwdValid, wb_misalign;
    logic [REG_ADDR_W-1:0] writeAddr;
    logic [31:0] writeData;
`ifdef WB_RETIRE_CNT_EN
    logic [RETIRE_CNT_W-1:0] retireCount;
`endif
    modport master (
        output stall, flush, mem_valid, mem_regWrite, mem_memToReg, mem_loadType,
               mem_destReg, mem_aluResult, mem_readData,
        input  writeEn, writeAddr, writeData, wb_fwdValid, wb_misalign
`ifdef WB_RETIRE_CNT_EN
        , input retireCount
`endif
    );
    modport slave (
        input  stall, flush, mem_valid, mem_regWrite, mem_memToReg, mem_loadType,
               mem_destReg, mem_aluResult, mem_readData,
        output writeEn, writeAddr, writeData, wb_fwdValid, wb_misalign
`ifdef WB_RETIRE_CNT_EN
        , output retireCount
`endif
    );
endinterface

// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB pipeline register plus load extension and register-file write port
// Optional: WB_RETIRE_CNT_EN adds a retired-instruction counter on retireCount.
// clk: clock. rst_n: synchronous active-low reset.
// bus (writeback_stage_if.slave):
//   in:  stall, flush, mem_* MEM-stage results
//   out: writeEn, writeAddr, writeData, wb_fwdValid, wb_misalign, retireCount
module writeback_stage #(
    parameter int REG_ADDR_W = 5
`ifdef WB_RETIRE_CNT_EN
    , parameter int RETIRE_CNT_W = 32
`endif
) (
    input logic clk,
    input logic rst_n,
    writeback_stage_if.slave bus
);
    logic v, rw, m2r;
    logic [2:0] lt;
    logic [REG_ADDR_W-1:0] dst;
    logic [31:0] alu, rd;
    // A flush only clears valid; the remaining fields are don't-care while valid=0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v   <= 1'b0;
            rw  <= 1'b0;
            m2r <= 1'b0;
            lt  <= '0;
            dst <= '0;
            alu <= '0;
            rd  <= '0;
        end else if (bus.flush) begin
            v <= 1'b0;
        end else if (!bus.stall) begin
            v   <= bus.mem_valid;
            rw  <= bus.mem_regWrite;
            m2r <= bus.mem_memToReg;
            lt  <= bus.mem_loadType;
            dst <= bus.mem_destReg;
            alu <= bus.mem_aluResult;
            rd  <= bus.mem_readData;
        end
    end
    logic [7:0] b;
    logic [15:0] h;
    logic [31:0] ld;
    logic mis, we;
    // Load type codes 1..4 are LB, LBU, LH, LHU; everything else behaves as LW.
    always_comb begin
        b   = rd[{alu[1:0], 3'b000} +: 8];
        h   = alu[1] ? rd[31:16] : rd[15:0];
        ld  = lt == 3'd1 ? {{24{b[7]}}, b} :
              lt == 3'd2 ? {24'd0, b} :
              lt == 3'd3 ? {{16{h[15]}}, h} :
              lt == 3'd4 ? {16'd0, h} : rd;
        mis = v & m2r & (lt == 3'd3 | lt == 3'd4) & alu[0];
        we  = v & rw & (dst != '0) & ~mis;
    end
    assign bus.writeEn     = we;
    assign bus.wb_fwdValid = we;
    assign bus.wb_misalign = mis;
    assign bus.writeAddr   = we ? dst : '0;
    assign bus.writeData   = we ? (m2r ? ld : alu) : '0;
`ifdef WB_RETIRE_CNT_EN
    // Counts every unstalled WB-valid edge, independent of regWrite or misalign.
    logic [RETIRE_CNT_W-1:0] cnt;
    always_ff @(posedge clk) cnt <= !rst_n ? '0 : cnt + RETIRE_CNT_W'(v & ~bus.stall);
    assign bus.retireCount = cnt;
`endif
endmodule
